// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared 32-bit ALU.
// Each request is registered, executed in one cycle and held on a response channel until it is accepted.

module alu #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [1:0]   control,
    output logic [N-1:0] result,
    output logic         v,
    output logic         c,
    output logic         n,
    output logic         z
);
    logic [N-1:0] b_in;
    logic [N:0]   sum;
    logic [N-1:0] low;

    always_comb begin
        b_in = control[0] ? ~b : b;
        sum  = {1'b0, a} + {1'b0, b_in} + {{N{1'b0}}, control[0]};
        // carry into the sign bit; this is the V flag the datapath has always exported
        low  = {1'b0, a[N-2:0]} + {1'b0, b_in[N-2:0]} + {{(N-1){1'b0}}, control[0]};
        case (control)
            2'b10:   result = a & b;
            2'b11:   result = a | b;
            default: result = sum[N-1:0];
        endcase
        c = ~control[1] & sum[N];
        v = ~control[1] & low[N-1];
        n = result[N-1];
        z = ~|result;
    end
endmodule

// state | meaning
// IDLE  | waiting for a request; grants one requester per handshake
// EXEC  | operand registers drive the ALU; result captured at the edge
// RESP  | response registers valid until rsp_ready
module alu_arbiter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [N-1:0] a0,
    input  logic [N-1:0] b0,
    input  logic [1:0]   control0,
    input  logic [N-1:0] a1,
    input  logic [N-1:0] b1,
    input  logic [1:0]   control1,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] result,
    output logic         v,
    output logic         c,
    output logic         n,
    output logic         z,
    output logic [15:0]  count0,
    output logic [15:0]  count1
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]   state;
    logic         prio;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic [1:0]   op_ctl;
    logic         op_id;
    logic [N-1:0] alu_result;
    logic         alu_v;
    logic         alu_c;
    logic         alu_n;
    logic         alu_z;

    alu #(.N(N)) u_alu (
        .a       (op_a),
        .b       (op_b),
        .control (op_ctl),
        .result  (alu_result),
        .v       (alu_v),
        .c       (alu_c),
        .n       (alu_n),
        .z       (alu_z)
    );

    always_comb begin
        req_ready = 2'b00;
        if (!reset && state == IDLE) begin
            case (req_valid)
                2'b01:   req_ready = 2'b01;
                2'b10:   req_ready = 2'b10;
                2'b11:   req_ready = prio ? 2'b10 : 2'b01;
                default: req_ready = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            prio      <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            op_ctl    <= 2'b00;
            op_id     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            result    <= '0;
            v         <= 1'b0;
            c         <= 1'b0;
            n         <= 1'b0;
            z         <= 1'b0;
            count0    <= 16'h0000;
            count1    <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_ready) begin
                        op_a   <= req_ready[1] ? a1 : a0;
                        op_b   <= req_ready[1] ? b1 : b0;
                        op_ctl <= req_ready[1] ? control1 : control0;
                        op_id  <= req_ready[1];
                        prio   <= ~req_ready[1];
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    result    <= alu_result;
                    v         <= alu_v;
                    c         <= alu_c;
                    n         <= alu_n;
                    z         <= alu_z;
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (rsp_id) count1 <= count1 + 16'd1;
                        else        count0 <= count0 + 16'd1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: reference arbiter model, response scoreboard,
// directed vector table and multi-cycle corner sequences.

module tb_alu_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] a0, b0, a1, b1;
    logic [1:0]  control0, control1;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] result;
    logic        v, c, n, z;
    logic [15:0] count0, count1;

    alu_arbiter #(.N(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .a0        (a0),
        .b0        (b0),
        .control0  (control0),
        .a1        (a1),
        .b1        (b1),
        .control1  (control1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .result    (result),
        .v         (v),
        .c         (c),
        .n         (n),
        .z         (z),
        .count0    (count0),
        .count1    (count1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  valid;
        logic [31:0] a0, b0, a1, b1;
        logic [1:0]  c0, c1;
        logic        exp_id;
        logic [31:0] exp_res;
        logic        ev, ec, en, ez;
        logic        chk_v;
    } vec_t;

    typedef struct {
        logic        id;
        logic [31:0] res;
        logic        v, c, n, z;
        logic        logic_op;
    } exp_t;

    vec_t        vecs[6];
    exp_t        sb[$];
    logic        glog[$];
    int          total = 0;
    int          bad = 0;
    int          m_state = 0;
    logic        m_prio = 1'b0;
    logic [15:0] m_cnt0 = 16'h0000;
    logic [15:0] m_cnt1 = 16'h0000;
    logic        last_id;
    logic [31:0] last_res;
    logic        last_v, last_c, last_n, last_z;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mdl(input logic [31:0] a, input logic [31:0] b,
                                 input logic [1:0] ctl, input logic id);
        exp_t e;
        e.id = id;
        e.logic_op = ctl[1];
        e.v = 1'b0;
        e.c = 1'b0;
        case (ctl)
            2'b00: begin e.res = a + b; e.c = ({1'b0, a} + {1'b0, b}) > 33'h0FFFFFFFF; end
            2'b01: begin e.res = a - b; e.c = (a >= b); end
            2'b10: e.res = a & b;
            default: e.res = a | b;
        endcase
        e.n = e.res[31];
        e.z = (e.res == 32'h0);
        return e;
    endfunction

    // One clock: compare against the reference model, advance it, then step past the edge.
    task automatic cycle(output logic gv, output logic gi);
        logic [1:0] er;
        exp_t e;
        er = 2'b00;
        if (!reset && m_state == 0) begin
            case (req_valid)
                2'b01: er = 2'b01;
                2'b10: er = 2'b10;
                2'b11: er = m_prio ? 2'b10 : 2'b01;
                default: er = 2'b00;
            endcase
        end
        check("req_ready", {30'h0, req_ready}, {30'h0, er});
        check("rsp_valid", {31'h0, rsp_valid}, {31'h0, (m_state == 2)});
        check("count0", {16'h0, count0}, {16'h0, m_cnt0});
        check("count1", {16'h0, count1}, {16'h0, m_cnt1});
        gv = 1'b0;
        gi = 1'b0;
        if (reset) begin
            m_state = 0;
            m_prio = 1'b0;
            m_cnt0 = 16'h0000;
            m_cnt1 = 16'h0000;
            sb.delete();
        end else begin
            case (m_state)
                0: if (er != 2'b00) begin
                    gv = 1'b1;
                    gi = er[1];
                    sb.push_back(gi ? mdl(a1, b1, control1, 1'b1) : mdl(a0, b0, control0, 1'b0));
                    m_prio = ~gi;
                    m_state = 1;
                end
                1: m_state = 2;
                default: if (rsp_ready) begin
                    if (sb.size() == 0) begin
                        check("sb_nonempty", 32'h0, 32'h1);
                    end else begin
                        e = sb.pop_front();
                        check("rsp_id", {31'h0, rsp_id}, {31'h0, e.id});
                        check("result", result, e.res);
                        check("flag_c", {31'h0, c}, {31'h0, e.c});
                        check("flag_n", {31'h0, n}, {31'h0, e.n});
                        check("flag_z", {31'h0, z}, {31'h0, e.z});
                        if (e.logic_op) check("flag_v_logic", {31'h0, v}, 32'h0);
                        if (e.id) m_cnt1 = m_cnt1 + 16'd1;
                        else      m_cnt0 = m_cnt0 + 16'd1;
                    end
                    last_id = rsp_id; last_res = result;
                    last_v = v; last_c = c; last_n = n; last_z = z;
                    m_state = 0;
                end
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input string name, output logic gi);
        logic gv;
        logic got;
        got = 1'b0;
        gi = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin
            cycle(gv, gi);
            got = gv;
        end
        if (!got) check({name, "_grant_timeout"}, 32'h0, 32'h1);
    endtask

    task automatic drain(input string name);
        logic gv, gi;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        for (int k = 0; k < 12 && m_state != 0; k++) cycle(gv, gi);
        if (m_state != 0) check({name, "_drain_timeout"}, 32'h0, 32'h1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic gv, gi;
        int grants;

        vecs[0] = '{2'b01, 32'h7FFFFFFF, 32'h1, 32'h0, 32'h0, 2'b00, 2'b00,
                    1'b0, 32'h80000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{2'b10, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h1, 2'b00, 2'b00,
                    1'b1, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{2'b10, 32'h0, 32'h0, 32'hF0F0F0F0, 32'hFF00FF00, 2'b00, 2'b10,
                    1'b1, 32'hF000F000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{2'b01, 32'h0, 32'h0, 32'h0, 32'h0, 2'b11, 2'b00,
                    1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{2'b01, 32'h3, 32'h5, 32'h0, 32'h0, 2'b01, 2'b00,
                    1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        // both valid with prio left at 1 by the previous requester-0 grant
        vecs[5] = '{2'b11, 32'h1, 32'h1, 32'hA, 32'h4, 2'b00, 2'b01,
                    1'b1, 32'h00000006, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        reset = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        a0 = 0; b0 = 0; a1 = 0; b1 = 0; control0 = 0; control1 = 0;
        @(posedge clk); #1;
        cycle(gv, gi);
        reset = 1'b0;
        check("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("reset_result", result, 32'h0);
        check("reset_flags", {28'h0, v, c, n, z}, 32'h0);
        check("reset_rsp_id", {31'h0, rsp_id}, 32'h0);

        for (int i = 0; i < 6; i++) begin
            req_valid = vecs[i].valid;
            a0 = vecs[i].a0; b0 = vecs[i].b0; control0 = vecs[i].c0;
            a1 = vecs[i].a1; b1 = vecs[i].b1; control1 = vecs[i].c1;
            rsp_ready = 1'b1;
            wait_grant("vec", gi);
            check("vec_grant_id", {31'h0, gi}, {31'h0, vecs[i].exp_id});
            // first response cycle lands two cycles after the handshake
            cycle(gv, gi);
            check("vec_latency", {31'h0, rsp_valid}, 32'h1);
            drain("vec");
            check("vec_rsp_id", {31'h0, last_id}, {31'h0, vecs[i].exp_id});
            check("vec_result", last_res, vecs[i].exp_res);
            check("vec_cnz", {29'h0, last_c, last_n, last_z},
                  {29'h0, vecs[i].ec, vecs[i].en, vecs[i].ez});
            if (vecs[i].chk_v) check("vec_v", {31'h0, last_v}, {31'h0, vecs[i].ev});
        end

        // backpressure: hold RESP, keep both requesters waiting
        req_valid = 2'b01;
        a0 = 32'h12345678; b0 = 32'h11111111; control0 = 2'b00;
        rsp_ready = 1'b0;
        wait_grant("bp", gi);
        req_valid = 2'b11;
        a0 = 32'h1; b0 = 32'h2; a1 = 32'h3; b1 = 32'h1; control1 = 2'b01;
        cycle(gv, gi);
        for (int k = 0; k < 5; k++) begin
            check("bp_rsp_valid", {31'h0, rsp_valid}, 32'h1);
            check("bp_result", result, 32'h23456789);
            check("bp_flags", {27'h0, rsp_id, v, c, n, z}, 32'h0);
            check("bp_req_ready", {30'h0, req_ready}, 32'h0);
            cycle(gv, gi);
        end
        rsp_ready = 1'b1;
        cycle(gv, gi);
        check("bp_release_idle", {30'h0, req_ready}, 32'h2);
        wait_grant("bp_next", gi);
        check("bp_next_id", {31'h0, gi}, 32'h1);
        req_valid = 2'b01;
        wait_grant("bp_next0", gi);
        drain("bp");

        // reset while the operation sits in EXEC
        req_valid = 2'b01;
        a0 = 32'hDEADBEEF; b0 = 32'h1; control0 = 2'b00;
        wait_grant("rst", gi);
        reset = 1'b1;
        req_valid = 2'b11;
        check("rst_req_ready", {30'h0, req_ready}, 32'h0);
        cycle(gv, gi);
        reset = 1'b0;
        req_valid = 2'b00;
        check("rst_outputs", {29'h0, rsp_valid, rsp_id, |result}, 32'h0);
        check("rst_flags", {28'h0, v, c, n, z}, 32'h0);
        check("rst_counts", {count1, count0}, 32'h0);
        for (int k = 0; k < 4; k++) cycle(gv, gi);

        // fairness: both valid for six grants, and vs or
        req_valid = 2'b11;
        control0 = 2'b10; control1 = 2'b11;
        a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
        glog.delete();
        grants = 0;
        for (int k = 0; k < 40 && grants < 6; k++) begin
            cycle(gv, gi);
            if (gv) begin
                glog.push_back(gi);
                grants++;
                if (gi) begin a1 = $urandom; b1 = $urandom; end
                else    begin a0 = $urandom; b0 = $urandom; end
            end
        end
        check("fair_grants", grants, 6);
        drain("fair");
        for (int k = 0; k < glog.size(); k++)
            check("fair_order", {31'h0, glog[k]}, k % 2);
        check("fair_count0", {16'h0, count0}, 32'd3);
        check("fair_count1", {16'h0, count1}, 32'd3);

        // random traffic with random backpressure
        for (int k = 0; k < 120; k++) begin
            if (!req_valid[0] && $urandom_range(0, 1) == 1) begin
                a0 = $urandom; b0 = $urandom; control0 = 2'($urandom_range(0, 3));
                req_valid[0] = 1'b1;
            end
            if (!req_valid[1] && $urandom_range(0, 1) == 1) begin
                a1 = $urandom; b1 = $urandom; control1 = 2'($urandom_range(0, 3));
                req_valid[1] = 1'b1;
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle(gv, gi);
            if (gv) req_valid[gi] = 1'b0;
        end
        drain("rand");

        // counter wrap: preload near the top, then three requester-0 subtractions
        force dut.count0 = 16'hFFFD;
        #1;
        release dut.count0;
        m_cnt0 = 16'hFFFD;
        a0 = 32'd5; b0 = 32'd3; control0 = 2'b01;
        for (int k = 0; k < 3; k++) begin
            req_valid = 2'b01;
            wait_grant("wrap", gi);
            drain("wrap");
            check("wrap_result", last_res, 32'd2);
        end
        check("wrap_count0", {16'h0, count0}, 32'h0);
        cycle(gv, gi);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter that shares one instance of the team's 32-bit `alu` (add/sub/and/or with V/C/N/Z flags) between two requesters. Each requester presents operands and a 2-bit operation code through a valid/ready handshake. The block registers the winning request, runs it through the ALU, and returns result, flags and requester ID on a single response channel with its own valid/ready handshake. It sits between two issuing units and the shared ALU datapath.

## Interface
- `N`, 32, operand/result width; passed to the internal `alu`.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid[1:0]`  in  2  bit i: requester i presents a request.
- `req_ready[1:0]`  out  2  bit i: request i accepted this cycle. At most one bit high.
- `a0`, `b0` / `a1`, `b1`  in  N each  operands of requester 0 / 1.
- `control0` / `control1`  in  2 each  ALU op: 00 add, 01 sub, 10 and, 11 or.
- `rsp_valid`  out  1  response registers hold a completed operation.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  1  requester that issued the response.
- `result`  out  N  ALU result.
- `v`, `c`, `n`, `z`  out  1 each  ALU flags, captured with `result`.
- `count0`, `count1`  out  16 each  completed responses per requester; wrap modulo 2^16.

## Operation
- States: IDLE, EXEC, RESP. Reset enters IDLE.
- IDLE:
  - If no `req_valid` bit is set, stay in IDLE.
  - Otherwise pick a winner. If only one requester is valid, it wins. If both are valid, the requester named by the priority pointer `prio` wins.
  - Assert `req_ready` for the winner only. `req_ready` is combinational from state, `req_valid` and `prio`.
  - On the handshake, latch a, b, control and ID into operand registers, set `prio` to the other requester, and go to EXEC.
- EXEC:
  - The ALU is fed only from the operand registers.
  - At the end of the cycle, capture `result`, v, c, n, z and `rsp_id` into output registers and go to RESP.
- RESP:
  - `rsp_valid` is 1.
  - If `rsp_ready` is 1, complete the transfer: increment `count[rsp_id]` and go to IDLE.
  - Otherwise hold every response output stable.
- Flags are the ALU flags unchanged. The arbiter does not reinterpret V/C for logical ops.
- `req_ready` is 0 in EXEC and RESP. Requests that are not granted must hold valid and operands until granted; the arbiter never drops them.
- `prio` changes only on a grant, so a requester waiting against a continuously valid opponent is served on the next grant.

## Timing
- Reset values:
  - state IDLE, `prio` = 0;
  - `rsp_valid`, `rsp_id`, `result`, v, c, n, z = 0;
  - `count0`, `count1` = 0;
  - `req_ready` = 0 while `reset` is high.
- Handshake at edge t, with no backpressure:
  - `rsp_valid` rises after edge t+1 (visible in cycle t+2).
  - A `rsp_ready` already high completes the response at edge t+2.
  - The next grant is possible in the cycle after t+2.
- Peak throughput: one operation per 3 cycles.
- Backpressure: RESP holds indefinitely, with outputs bit-stable.
- Simultaneous `rsp_ready` and a new `req_valid` in RESP: the response completes and the new request waits for IDLE; no same-cycle grant.
- Reset in EXEC or RESP: the pending operation is discarded, no counter increments, and all outputs return to reset values on the next edge.
- Counter wrap: 16'hFFFF + 1 = 16'h0000, with no saturation.

## Test plan
- Single add: `req_valid` = 01, a0 = 32'h7FFFFFFF, b0 = 1, `control0` = 00, `rsp_ready` = 1 -> `rsp_valid` 2 cycles after the handshake, `result` = 32'h80000000, v = 1, c = 0, n = 1, z = 0, `rsp_id` = 0, `count0` = 1.
- Carry/zero: requester 1, a1 = 32'hFFFFFFFF, b1 = 1, `control1` = 00 -> `result` = 0, z = 1, c = 1, v = 1, n = 0, `rsp_id` = 1.
- Fairness: both requesters valid continuously for 6 grants, requester 0 doing and, requester 1 doing or -> grant order 0,1,0,1,0,1; `count0` = `count1` = 3; `req_ready` never 2'b11.
- Backpressure: `rsp_ready` = 0 for 5 cycles in RESP -> `rsp_valid` stays 1, result and flags stable, `req_ready` = 00; on `rsp_ready` = 1 -> IDLE next cycle.
- Reset mid-EXEC: assert `reset` one cycle after the handshake -> no response, counters 0, all outputs 0, `prio` = 0.
- Wrap: preload 65536 requester-0 ops (sub, a0 = 5, b0 = 3 -> `result` = 2) -> `count0` returns to 0 after the last one.
